// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end with PC-tagged response queue
// Issues sequential fetches, queues in-order responses, flushes on taken-branch redirect.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(QDEPTH);

   logic [31:0]       fetch_pc;
   logic [31:0]       pc_q    [QDEPTH];
   logic [31:0]       instr_q [QDEPTH];
   logic [QDEPTH-1:0] filled_q;
   logic [AW-1:0]     head, tail, alloc;
   logic [CW-1:0]     count, pend_cnt, drop_cnt;
   logic [31:0]       last_pc, last_instr;
   logic [CW:0]       occ, drop_sum;
   logic              accept, pop, rsp_drop, rsp_fill, rsp_take;
   logic              unused_ok;

   // drop_cnt slots stay reserved so stale responses can never overrun the queue
   assign occ            = {1'b0, count} + {1'b0, drop_cnt};
   assign imem_req_valid = resetn && !redirect_valid && (occ < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign if_valid = filled_q[head] && !redirect_valid;
   assign pop      = if_valid && if_ready;
   assign if_pc    = filled_q[head] ? pc_q[head]    : last_pc;
   assign if_instr = filled_q[head] ? instr_q[head] : last_instr;

   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);
   assign rsp_take = rsp_drop || rsp_fill;
   // everything still outstanding after this cycle's response must be discarded
   assign drop_sum = {1'b0, drop_cnt} + {1'b0, pend_cnt} - {{CW{1'b0}}, rsp_take};

   assign unused_ok = ^{redirect_pc[1:0], drop_sum[CW]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc   <= RESET_PC;
         filled_q   <= '0;
         head       <= '0;
         tail       <= '0;
         alloc      <= '0;
         count      <= '0;
         pend_cnt   <= '0;
         drop_cnt   <= '0;
         last_pc    <= '0;
         last_instr <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         filled_q <= '0;
         head     <= '0;
         tail     <= '0;
         alloc    <= '0;
         count    <= '0;
         pend_cnt <= '0;
         drop_cnt <= drop_sum[CW-1:0];
      end else begin
         if (accept) begin
            pc_q[tail] <= fetch_pc;
            tail       <= tail + 1'b1;
            fetch_pc   <= fetch_pc + 32'd4;
         end
         if (rsp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
         if (rsp_fill) begin
            instr_q[alloc]  <= imem_rsp_data;
            filled_q[alloc] <= 1'b1;
            alloc           <= alloc + 1'b1;
         end
         if (pop) begin
            filled_q[head] <= 1'b0;
            head           <= head + 1'b1;
            last_pc        <= pc_q[head];
            last_instr     <= instr_q[head];
         end
         count    <= count + CW'(accept) - CW'(pop);
         pend_cnt <= pend_cnt + CW'(accept) - CW'(rsp_fill);
      end
   end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench for if_fetch_queue
// Fixed-latency memory model plus an in-order PC/instruction scoreboard.
module tb_if_fetch_queue;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QDEPTH   = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   if_fetch_queue #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a * 32'd3 + 32'h13;
   endfunction

   int          mem_lat = 1;
   int          cyc     = 0;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] exp_pc;
   logic [31:0] first_pc;
   int          n_acc, n_pop;
   bit          saw_zero;
   bit          prev_stall;
   logic [31:0] prev_addr;
   logic        s_req_valid, s_if_valid;
   logic [31:0] s_addr, s_if_pc;

   // one clock cycle: drive memory response, sample, score, advance
   task automatic tick();
      if (mq_due.size() > 0 && mq_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(mq_addr[0]);
         void'(mq_due.pop_front());
         void'(mq_addr.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hdead_beef;
      end
      #1;
      s_req_valid = imem_req_valid;
      s_addr      = imem_req_addr;
      s_if_valid  = if_valid;
      s_if_pc     = if_pc;
      if (redirect_valid) begin
         check("redir_mask_if", if_valid, 32'd0);
         check("redir_mask_req", imem_req_valid, 32'd0);
      end else if (prev_stall) begin
         check("stall_valid", imem_req_valid, 32'd1);
         check("stall_addr", imem_req_addr, prev_addr);
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + mem_lat);
         n_acc++;
      end
      if (if_valid && if_ready) begin
         check("pop_pc", if_pc, exp_pc);
         check("pop_instr", if_instr, instr_of(exp_pc));
         if (n_pop == 0) first_pc = if_pc;
         if (if_pc == 32'd0) saw_zero = 1'b1;
         n_pop++;
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if_ready       = 1'b1;
      repeat (2) @(posedge clk);
      mq_addr.delete();
      mq_due.delete();
      cyc        = 0;
      exp_pc     = RESET_PC;
      first_pc   = 32'hffff_ffff;
      n_acc      = 0;
      n_pop      = 0;
      saw_zero   = 1'b0;
      prev_stall = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if_ready       = 1'b1;
      #3;
      check("rst_req_valid", imem_req_valid, 32'd0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check("rst_if_valid", if_valid, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);

      // streaming at 1-cycle latency
      do_reset();
      mem_lat = 1;
      tick();
      check("t1_c0_req", s_req_valid, 32'd1);
      check("t1_c0_addr", s_addr, RESET_PC);
      check("t1_c0_ifv", s_if_valid, 32'd0);
      tick();
      check("t1_c1_addr", s_addr, 32'h4);
      check("t1_c1_ifv", s_if_valid, 32'd0);
      tick();
      check("t1_c2_ifv", s_if_valid, 32'd1);
      check("t1_c2_pc", s_if_pc, 32'h0);
      tick();
      check("t1_c3_pc", s_if_pc, 32'h4);
      repeat (6) tick();
      check("t1_pops", n_pop, 32'd8);

      // stall until full, then drain
      do_reset();
      if_ready = 1'b0;
      repeat (10) tick();
      check("t2_accepts", n_acc, QDEPTH);
      check("t2_full_req", s_req_valid, 32'd0);
      check("t2_next_addr", s_addr, 32'h10);
      check("t2_full_ifv", s_if_valid, 32'd1);
      if_ready = 1'b1;
      repeat (12) tick();
      check("t2_pops", n_pop, 32'd12);
      check("t2_first", first_pc, 32'h0);

      // 3-cycle memory, redirect with 2 outstanding, then back-to-back redirects
      do_reset();
      mem_lat = 3;
      tick();
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      check("t3_outstanding", n_acc, 32'd2);
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      n_pop = 0;
      tick();
      check("t3_tgt_req", s_req_valid, 32'd1);
      check("t3_tgt_addr", s_addr, 32'h100);
      repeat (8) tick();
      check("t3_popped", n_pop > 0, 32'd1);
      check("t3_first", first_pc, 32'h100);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_pc = 32'h400;
      tick();
      redirect_valid = 1'b0;
      n_pop = 0;
      repeat (12) tick();
      check("t3b_popped", n_pop > 0, 32'd1);
      check("t3b_first", first_pc, 32'h400);

      // redirect coinciding with a response and a pop
      do_reset();
      mem_lat = 1;
      repeat (4) tick();
      check("t4_pre_ifv", s_if_valid, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      redirect_valid = 1'b0;
      n_pop = 0;
      tick();
      check("t4_r1_req", s_req_valid, 32'd1);
      check("t4_r1_addr", s_addr, 32'h200);
      check("t4_r1_ifv", s_if_valid, 32'd0);
      check("t4_r1_hold_pc", s_if_pc, 32'h4);
      tick();
      check("t4_r2_ifv", s_if_valid, 32'd0);
      tick();
      check("t4_r3_ifv", s_if_valid, 32'd1);
      check("t4_r3_pc", s_if_pc, 32'h200);
      repeat (5) tick();
      check("t4_first", first_pc, 32'h200);

      // random request backpressure across the 32-bit wrap
      do_reset();
      mem_lat = 2;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hffff_fff0;
      tick();
      redirect_valid = 1'b0;
      n_pop    = 0;
      saw_zero = 1'b0;
      for (int i = 0; i < 80; i++) begin
         imem_req_ready = 1'($urandom_range(0, 1));
         if_ready       = ($urandom_range(0, 3) != 0);
         tick();
      end
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      check("t5_first", first_pc, 32'hffff_fff0);
      check("t5_wrapped", saw_zero, 32'd1);

      // reset mid-stream with a full queue
      do_reset();
      mem_lat  = 1;
      if_ready = 1'b0;
      repeat (8) tick();
      check("t6_full_ifv", s_if_valid, 32'd1);
      check("t6_full_req", s_req_valid, 32'd0);
      resetn = 1'b0;
      #1;
      check("t6_rst_req", imem_req_valid, 32'd0);
      check("t6_rst_ifv", if_valid, 32'd0);
      do_reset();
      tick();
      check("t6_restart_req", s_req_valid, 32'd1);
      check("t6_restart_addr", s_addr, RESET_PC);
      repeat (5) tick();
      check("t6_first", first_pc, RESET_PC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
